// File: rtl/ibex_mem_arb.sv
// Two-to-one req/gnt/rvalid arbiter joining the Ibex fetch and load/store ports onto one memory port.
// Define IBEX_MEM_ARB_DATA_PRIO_EN to make data win every tie; otherwise ties are round-robin.
module ibex_mem_arb #(
  parameter int unsigned MaxReqs = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  localparam int unsigned CW     = $clog2(MaxReqs + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_req_i,
  output logic            instr_gnt_o,
  input  logic [AW-1:0]   instr_addr_i,
  output logic            instr_rvalid_o,
  output logic [DW-1:0]   instr_rdata_o,
  output logic            instr_err_o,
  input  logic            data_req_i,
  output logic            data_gnt_o,
  input  logic            data_we_i,
  input  logic [DW/8-1:0] data_be_i,
  input  logic [AW-1:0]   data_addr_i,
  input  logic [DW-1:0]   data_wdata_i,
  output logic            data_rvalid_o,
  output logic [DW-1:0]   data_rdata_o,
  output logic            data_err_o,
  output logic            req_o,
  input  logic            gnt_i,
  output logic            we_o,
  output logic [DW/8-1:0] be_o,
  output logic [AW-1:0]   addr_o,
  output logic [DW-1:0]   wdata_o,
  input  logic            rvalid_i,
  input  logic [DW-1:0]   rdata_i,
  input  logic            err_i,
  output logic [CW-1:0]   outstanding_o,
  output logic            proto_err_o
);

  // state     | meaning
  // ST_OPEN   | no pending ungranted request; selection follows the arbiter
  // ST_LOCKED | request presented but not granted; sel_q held until gnt_i
  typedef enum logic {ST_OPEN, ST_LOCKED} state_e;

  localparam int unsigned PW = (MaxReqs > 1) ? $clog2(MaxReqs) : 1;
  localparam logic SRC_INSTR = 1'b0;
  localparam logic SRC_DATA  = 1'b1;

  state_e              state_q, state_d;
  logic                sel_q, last_q, sel, tie_win, credit;
  logic                push, pop, head;
  logic [MaxReqs-1:0]  fifo_q;
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [CW-1:0]       cnt_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MaxReqs - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef IBEX_MEM_ARB_DATA_PRIO_EN
  assign tie_win = SRC_DATA;
`else
  assign tie_win = ~last_q;
`endif

  always_comb begin
    state_d = state_q;
    sel     = SRC_INSTR;
    credit  = (cnt_q < CW'(MaxReqs));
    if (state_q == ST_LOCKED)           sel = sel_q;
    else if (instr_req_i && data_req_i) sel = tie_win;
    else if (data_req_i)                sel = SRC_DATA;

    req_o       = credit & ((sel == SRC_DATA) ? data_req_i : instr_req_i);
    we_o        = (sel == SRC_DATA) & data_we_i;
    be_o        = (sel == SRC_DATA) ? data_be_i : '1;
    addr_o      = (sel == SRC_DATA) ? data_addr_i : instr_addr_i;
    wdata_o     = (sel == SRC_DATA) ? data_wdata_i : '0;
    instr_gnt_o = gnt_i & req_o & (sel == SRC_INSTR);
    data_gnt_o  = gnt_i & req_o & (sel == SRC_DATA);

    case (state_q)
      ST_OPEN:   if (req_o && !gnt_i) state_d = ST_LOCKED;
      ST_LOCKED: if (gnt_i)           state_d = ST_OPEN;
      default:                        state_d = ST_OPEN;
    endcase
  end

  // Responses always come back in grant order, so the FIFO head names the owner.
  assign push           = req_o & gnt_i;
  assign pop            = rvalid_i & (cnt_q != '0);
  assign head           = fifo_q[rptr_q];
  assign instr_rvalid_o = pop & (head == SRC_INSTR);
  assign data_rvalid_o  = pop & (head == SRC_DATA);
  assign instr_rdata_o  = rdata_i;
  assign data_rdata_o   = rdata_i;
  assign instr_err_o    = err_i;
  assign data_err_o     = err_i;
  assign outstanding_o  = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_OPEN;
      sel_q       <= SRC_INSTR;
      last_q      <= SRC_INSTR;
      fifo_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      proto_err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_OPEN && req_o && !gnt_i) sel_q <= sel;
      if (push) begin
        fifo_q[wptr_q] <= sel;
        wptr_q         <= ptr_inc(wptr_q);
        last_q         <= sel;
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (rvalid_i && cnt_q == '0) proto_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ibex_mem_arb.sv
// Directed scoreboard bench for ibex_mem_arb (MaxReqs=2): expected owners are queued at grant
// and popped when a response is driven.
module tb_ibex_mem_arb;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i, be_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        req_o, gnt_i, we_o, rvalid_i, err_i, proto_err_o;
  logic [31:0] addr_o, wdata_o, rdata_i;
  logic [1:0]  outstanding_o;

  int   checks = 0;
  int   errors = 0;
  logic resp_q[$];

  ibex_mem_arb #(.MaxReqs(2), .AW(32), .DW(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i),
    .outstanding_o(outstanding_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // exp_g: -1 no grant, 0 instr grant, 1 data grant
  task automatic do_cycle(input logic ireq, input logic dreq, input logic gnt, input logic rv,
                          input logic [31:0] rd, input logic er, input int exp_g);
    logic s;
    @(negedge clk_i);
    instr_req_i = ireq; data_req_i = dreq; gnt_i = gnt;
    rvalid_i = rv; rdata_i = rd; err_i = er;
    #1;
    chk("instr_gnt", {31'b0, instr_gnt_o}, {31'b0, exp_g == 0});
    chk("data_gnt", {31'b0, data_gnt_o}, {31'b0, exp_g == 1});
    if (rv && resp_q.size() > 0) begin
      s = resp_q.pop_front();
      chk("instr_rvalid", {31'b0, instr_rvalid_o}, {31'b0, !s});
      chk("data_rvalid", {31'b0, data_rvalid_o}, {31'b0, s});
      if (s) begin
        chk("data_rdata", data_rdata_o, rd);
        chk("data_err", {31'b0, data_err_o}, {31'b0, er});
      end else begin
        chk("instr_rdata", instr_rdata_o, rd);
        chk("instr_err", {31'b0, instr_err_o}, {31'b0, er});
      end
    end else begin
      chk("instr_rvalid_idle", {31'b0, instr_rvalid_o}, 32'd0);
      chk("data_rvalid_idle", {31'b0, data_rvalid_o}, 32'd0);
    end
    if (exp_g >= 0) resp_q.push_back(exp_g == 1);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    instr_req_i = 0; data_req_i = 0; gnt_i = 0; rvalid_i = 0; rdata_i = 0; err_i = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    resp_q.delete();
    #1;
    chk("rst_outstanding", {30'b0, outstanding_o}, 32'd0);
    chk("rst_req", {31'b0, req_o}, 32'd0);
    chk("rst_proto_err", {31'b0, proto_err_o}, 32'd0);
    chk("rst_instr_rvalid", {31'b0, instr_rvalid_o}, 32'd0);
    chk("rst_data_rvalid", {31'b0, data_rvalid_o}, 32'd0);
  endtask

  initial begin
    instr_addr_i = 32'h0000_1000;
    data_addr_i  = 32'h0000_2000;
    data_wdata_i = 32'hCAFE_F00D;
    data_we_i    = 1'b1;
    data_be_i    = 4'h3;
    do_reset();

    // Round-robin tie after reset: data, instr, data, instr, with interleaved responses.
    do_cycle(1, 1, 1, 0, 32'h0, 0, 1);
    do_cycle(1, 1, 1, 1, 32'h1111_1111, 0, 0);
    do_cycle(1, 1, 1, 1, 32'h2222_2222, 0, 1);
    chk("pushpop_outstanding", {30'b0, outstanding_o}, 32'd1);
    do_cycle(1, 1, 1, 1, 32'hDEAD_BEEF, 1, 0);
    chk("pushpop_outstanding2", {30'b0, outstanding_o}, 32'd1);
    do_cycle(0, 0, 0, 1, 32'h3333_3333, 0, -1);
    do_cycle(0, 0, 0, 0, 32'h0, 0, -1);
    chk("drained", {30'b0, outstanding_o}, 32'd0);

    // Fill to MaxReqs, observe back-pressure, free one slot.
    do_cycle(1, 0, 1, 0, 32'h0, 0, 0);
    chk("instr_we", {31'b0, we_o}, 32'd0);
    chk("instr_be", {28'b0, be_o}, 32'hF);
    chk("instr_wdata", wdata_o, 32'd0);
    chk("instr_addr", addr_o, 32'h0000_1000);
    do_cycle(1, 0, 1, 0, 32'h0, 0, 0);
    do_cycle(1, 1, 1, 0, 32'h0, 0, -1);
    chk("full_req", {31'b0, req_o}, 32'd0);
    chk("full_outstanding", {30'b0, outstanding_o}, 32'd2);
    do_cycle(1, 1, 1, 1, 32'h4444_4444, 0, -1);
    chk("full_no_bypass", {31'b0, req_o}, 32'd0);
    do_cycle(1, 1, 1, 0, 32'h0, 0, 1);
    chk("credit_back_outstanding", {30'b0, outstanding_o}, 32'd1);
    chk("credit_back_req", {31'b0, req_o}, 32'd1);
    chk("data_addr", addr_o, 32'h0000_2000);
    chk("data_we", {31'b0, we_o}, 32'd1);
    chk("data_be", {28'b0, be_o}, 32'h3);
    chk("data_wdata", wdata_o, 32'hCAFE_F00D);
    do_cycle(0, 0, 0, 1, 32'h5555_5555, 0, -1);
    do_cycle(0, 0, 0, 1, 32'h6666_6666, 1, -1);

    // Lock: instr stalled without grant while data joins; instr must win.
    do_cycle(1, 0, 0, 0, 32'h0, 0, -1);
    chk("lock_req", {31'b0, req_o}, 32'd1);
    do_cycle(1, 1, 0, 0, 32'h0, 0, -1);
    chk("lock_addr", addr_o, 32'h0000_1000);
    do_cycle(1, 1, 0, 0, 32'h0, 0, -1);
    do_cycle(1, 1, 1, 0, 32'h0, 0, 0);
    do_cycle(1, 1, 1, 0, 32'h0, 0, 1);
    do_cycle(0, 0, 0, 1, 32'h7777_7777, 0, -1);
    do_cycle(0, 0, 0, 1, 32'h8888_8888, 0, -1);

    // Spurious response on an empty FIFO is sticky until reset.
    chk("proto_err_clear", {31'b0, proto_err_o}, 32'd0);
    do_cycle(0, 0, 0, 1, 32'h9999_9999, 0, -1);
    do_cycle(0, 0, 0, 0, 32'h0, 0, -1);
    chk("proto_err_set", {31'b0, proto_err_o}, 32'd1);
    chk("spurious_outstanding", {30'b0, outstanding_o}, 32'd0);
    do_cycle(0, 0, 0, 0, 32'h0, 0, -1);
    chk("proto_err_sticky", {31'b0, proto_err_o}, 32'd1);

    // Reset with an entry outstanding: the late response is spurious.
    do_reset();
    do_cycle(0, 1, 1, 0, 32'h0, 0, 1);
    do_reset();
    do_cycle(0, 0, 0, 1, 32'hAAAA_AAAA, 0, -1);
    do_cycle(0, 0, 0, 0, 32'h0, 0, -1);
    chk("late_resp_proto_err", {31'b0, proto_err_o}, 32'd1);

    // Four ties from reset: all data with priority, else alternating.
    do_reset();
    data_be_i = 4'h5;
`ifdef IBEX_MEM_ARB_DATA_PRIO_EN
    do_cycle(1, 1, 1, 0, 32'h0, 0, 1);
    chk("prio_we", {31'b0, we_o}, 32'd1);
    chk("prio_be", {28'b0, be_o}, 32'h5);
    do_cycle(1, 1, 1, 1, 32'h0000_0001, 0, 1);
    do_cycle(1, 1, 1, 1, 32'h0000_0002, 0, 1);
    do_cycle(1, 1, 1, 1, 32'h0000_0003, 0, 1);
`else
    do_cycle(1, 1, 1, 0, 32'h0, 0, 1);
    chk("rr_we", {31'b0, we_o}, 32'd1);
    chk("rr_be", {28'b0, be_o}, 32'h5);
    do_cycle(1, 1, 1, 1, 32'h0000_0001, 0, 0);
    do_cycle(1, 1, 1, 1, 32'h0000_0002, 0, 1);
    do_cycle(1, 1, 1, 1, 32'h0000_0003, 0, 0);
`endif
    do_cycle(0, 0, 0, 1, 32'h0000_0004, 1, -1);
    do_cycle(0, 0, 0, 0, 32'h0, 0, -1);
    chk("final_outstanding", {30'b0, outstanding_o}, 32'd0);
    chk("final_proto_err", {31'b0, proto_err_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ibex_mem_arb.md
# ibex_mem_arb

Two-to-one request arbiter that lets the Ibex instruction-fetch and load/store ports share one downstream req/gnt/rvalid memory port. The downstream port feeds a single `tlul_adapter_host` instance, so a core-only subsystem needs only one TL-UL host link. The block selects a requester, holds that selection stable until grant, and records the source of every granted transaction in an in-order FIFO. It uses that FIFO to route each response back to the requester that issued it.

## Interface
- `MaxReqs`, default 2: maximum outstanding granted transactions and the depth of the source FIFO; legal range 1..8.
- `AW`, default 32: address width.
- `DW`, default 32: data width; byte-enable width is DW/8.

- `clk_i` in 1: clock. One clock domain.
- `rst_i` in 1: reset. Synchronous and active-high.
- `instr_req_i` / `instr_gnt_o` in/out 1: fetch request and grant.
- `instr_addr_i` in AW: fetch address.
- `instr_rvalid_o` out 1: fetch response valid.
- `instr_rdata_o` out DW: fetch response data.
- `instr_err_o` out 1: fetch response error.
- `data_req_i` / `data_gnt_o` in/out 1: load/store request and grant.
- `data_we_i` in 1: write enable.
- `data_be_i` in DW/8: byte enables.
- `data_addr_i` in AW: load/store address.
- `data_wdata_i` in DW: write data.
- `data_rvalid_o` out 1: load/store response valid.
- `data_rdata_o` out DW: load/store response data.
- `data_err_o` out 1: load/store response error.
- `req_o` / `gnt_i` out/in 1: downstream request and grant.
- `we_o` out 1, `be_o` out DW/8, `addr_o` out AW, `wdata_o` out DW: downstream request fields.
- `rvalid_i` in 1, `rdata_i` in DW, `err_i` in 1: downstream response.
- `outstanding_o` out $clog2(MaxReqs+1): current FIFO occupancy.
- `proto_err_o` out 1: sticky flag; set when `rvalid_i` arrives with no outstanding transaction.

## Operation
- **Credit.** A request may be presented downstream only while the registered count is below MaxReqs. A response pop in the same cycle does not create credit; there is no bypass.
- **Selection.**
  - When `lock_q` is clear and credit is available, the requester is chosen combinationally from `instr_req_i` and `data_req_i`.
  - If both request, the arbitration policy decides (see Configuration).
  - The chosen source is driven onto `req_o` and the downstream request fields.
- **Instruction requests** drive `we_o`=0, `be_o`=all ones and `wdata_o`=0.
- **Lock.**
  - If `req_o`=1 and `gnt_i`=0, set `lock_q` and store the selected source in `sel_q`.
  - While `lock_q` is set, the stored source stays selected regardless of the other requester.
  - `lock_q` clears on `gnt_i`.
- **Grant.**
  - `instr_gnt_o` = `gnt_i` & `req_o` & (selected source is instruction).
  - `data_gnt_o` is the same with the data source.
  - The unselected requester's grant is 0.
- **Push.** On `req_o` & `gnt_i`:
  - write the source bit to the FIFO tail;
  - increment the count;
  - update the round-robin pointer `last_q` to the granted source.
- **Pop.**
  - On `rvalid_i` with count > 0: drive the matching `*_rvalid_o` for the source at the FIFO head, pass `rdata_i` and `err_i` to that port, and pop the FIFO.
  - The non-matching port's rvalid is 0. Its rdata and err are don't-care but must be free of X.
- **Simultaneous push and pop:** both happen and the count is unchanged.
- **Spurious response** (`rvalid_i` with count=0): no `*_rvalid_o` is asserted, the FIFO is unchanged, and `proto_err_o` is set until reset.
- **FIFO** is a circular buffer with read and write pointers that wrap modulo MaxReqs. The count is kept separately to tell full from empty.

## Timing
- No added request or response latency; all request, grant and response paths are combinational.
- State elements: FIFO contents and pointers, count, `lock_q`, `sel_q`, `last_q`, `proto_err_o`.
- Reset values (`rst_i` sampled high at a clock edge):
  - count=0, pointers=0, `lock_q`=0, `sel_q`=instr, `last_q`=instr, `proto_err_o`=0;
  - as a result `outstanding_o`=0, `req_o`=0 and both rvalid outputs are 0.
- **Reset mid-operation:** every outstanding entry is discarded. Any response that arrives after reset for a pre-reset transaction sets `proto_err_o`.
- **Full:** at count=MaxReqs, `req_o`=0 and both grants are 0 even when requests are pending.
- **Requester drop:** if a requester drops its request while locked, `req_o` follows the locked source's request and the lock persists. The requester is trusted to keep its request stable until grant.

## Configuration
- `IBEX_MEM_ARB_DATA_PRIO_EN` defined: data always wins a tie, and `last_q` has no effect.
- Not defined: round-robin. A tie is won by the source that is not `last_q`. After reset the first tie goes to data.

## Test plan
- **Tie after reset, round-robin:** hold both requests high with `gnt_i`=1 each cycle → grant order data, instr, data, instr; responses return to the matching ports in that order.
- **Full, MaxReqs=2:** make two grants with `rvalid_i`=0 → `outstanding_o`=2 and `req_o`=0. Pulse one `rvalid_i` → `outstanding_o`=1, then `req_o` rises in the following cycle.
- **Lock:** instr requests alone with `gnt_i`=0 for 3 cycles while data requests from cycle 1; then `gnt_i`=1 → `instr_gnt_o` pulses and `data_gnt_o` stays 0 throughout.
- **Simultaneous push and pop at count=1:** `outstanding_o` stays 1 and rdata 0xDEADBEEF with `err_i`=1 appears on the head source's port only.
- **Spurious response:** `rvalid_i` with FIFO empty → no rvalid outputs, `proto_err_o`=1 until `rst_i`.
- **Data priority with macro defined:** tie 4 times → `data_gnt_o` all 4 times; writes present `be_o`=`data_be_i` and `we_o`=1.
